instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Multi-cycle MIPS fetch stage. It drives the instruction word whose opcode/funct fields
//  feed the control decoder, and it consumes the decoder's branch/jump outcome to pick the next PC.
//  It runs a req/ack handshake with instruction memory, holds one instruction stable while the
//  datapath executes it, then redirects or increments the PC.
// PARAMETERS
//  ADDR_WIDTH  32            byte-address width of PC and imemAddr
//  RESET_PC    32'h00000000  first fetch address after reset; word aligned
//  MAX_WAIT    16            fetch watchdog limit in cycles (used only with IFU_TIMEOUT_EN)
// PORTS
//  clk                clock   in   1           single clock, rising edge
//  rstN               reset   in   1           asynchronous assert, active-low
//  imemReq            out   1           fetch request; held high until imemAck
//  imemAddr           out   ADDR_WIDTH  fetch byte address; stable while imemReq=1
//  imemAck            in    1           memory accepts request; imemData valid this cycle
//  imemData           in    32          instruction word
//  instrValid         out   1           instrOut/opcode/funct are valid and held
//  instrOut           out   32          current instruction register
//  instructionOpcode  out   6           instrOut[31:26]
//  instructionFunct   out   6           instrOut[5:0]
//  pcOut              out   ADDR_WIDTH  address of the current instruction
//  pcPlus4            out   ADDR_WIDTH  pcOut+4, wraps modulo 2^ADDR_WIDTH
//  instrDone          in    1           datapath has finished the current instruction
//  controlBranch      in    1           decoder: instruction is a branch (beq)
//  controlJump        in    1           decoder: instruction is a jump
//  aluZero            in    1           ALU zero flag, sampled with instrDone
//  fetchError         out   1           sticky watchdog error (IFU_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  Reset (rstN=0, async): state=RST; imemReq=0; imemAddr=pcOut=RESET_PC; instrValid=0;
//   instrOut=0; fetchError=0. An in-flight request is dropped. Release is sampled on clk.
//  FSM: RST -> FETCH (1 cycle after reset release).
//   FETCH: imemReq=1, imemAddr=pcOut. On imemAck: instrOut<=imemData, instrValid<=1 -> HOLD.
//    An ack in the first FETCH cycle is legal; instrValid rises the next cycle (1-cycle latency).
//   HOLD: instrValid=1 and instrOut is frozen. imemReq=0. Wait for instrDone.
//    On instrDone: compute the next PC, pcOut<=nextPC, instrValid<=0 -> FETCH.
//   ERROR (IFU_TIMEOUT_EN only): imemReq=0, instrValid=0, fetchError=1. Left only by reset.
//  nextPC, evaluated with instrDone in the same cycle:
//   controlJump=1                      -> {pcPlus4[31:28], instrOut[25:0], 2'b00}
//   controlBranch=1 and aluZero=1      -> pcPlus4 + (signext(instrOut[15:0]) << 2)
//   otherwise                          -> pcPlus4
//   If controlJump and controlBranch are both 1, the jump wins.
//   All additions are modulo 2^ADDR_WIDTH and wrap silently.
//  Ignored inputs: imemAck outside FETCH; instrDone outside HOLD. The branch and jump controls are
//   sampled only on the instrDone cycle.
//  Downstream must gate the decoder outputs with instrValid: a reset instrOut of 0 decodes as R-type.
// CONFIGURATION
//  IFU_TIMEOUT_EN defined: a counter clears on entry to FETCH and increments each FETCH cycle without
//   imemAck. When the count reaches MAX_WAIT the FSM moves to ERROR and fetchError latches 1.
//   An ack in the same cycle the limit is reached wins and the fetch completes.
//  IFU_TIMEOUT_EN undefined: no counter and no ERROR state; FETCH waits indefinitely; fetchError=0.
// TESTING
//  1. Reset, then ack after 2 wait cycles with data 0x8C010004
//     -> imemAddr=0x0 while waiting; instrValid=1 the cycle after ack; opcode=0x23; pcOut=0x0.
//  2. Sequential: instrDone with no branch or jump at pc 0x0
//     -> next FETCH imemAddr=0x4; pcPlus4=0x8 once that fetch is held.
//  3. beq at pc 0x10, imm 0x0003, controlBranch=1, aluZero=1
//     -> next fetch at 0x20. Repeat with aluZero=0 -> next fetch at 0x14.
//  4. Backward branch at pc 0x20, imm 0xFFFF, taken -> next fetch at 0x20.
//     Jump 0x08000040 at pc 0x100 with controlBranch also 1 -> next fetch at 0x100 (jump priority).
//  5. IFU_TIMEOUT_EN with MAX_WAIT=4 and no ack -> fetchError=1 and imemReq=0 after 4 FETCH cycles.
//     Ack on the 4th cycle -> normal HOLD instead.
//  6. Deassert rstN mid-FETCH and mid-HOLD -> all outputs go to reset values immediately.
//     After release, the fetch restarts at RESET_PC. A stray imemAck in HOLD changes nothing.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Multi-cycle MIPS fetch stage. It requests one instruction word from
// instruction memory with a req/ack handshake. It holds that word stable while
// the datapath executes it. When the datapath reports completion, it picks the
// next PC from the decoder's branch/jump outcome.
//
// Optional feature macro: IFU_TIMEOUT_EN
//   defined   : a fetch watchdog counts FETCH cycles without an ack. After
//               MAX_WAIT such cycles the unit parks in ERROR and raises a
//               sticky fetchError. Only reset clears it.
//   undefined : FETCH waits indefinitely and fetchError is tied low.
//
// Parameters
//   ADDR_WIDTH  byte-address width of the PC (must be at least 29 so the
//               jump target's upper PC bits exist)
//   RESET_PC    first fetch address after reset, word aligned
//   MAX_WAIT    watchdog limit in FETCH cycles (must be at least 1)
//
// Ports
//   clk               in   rising-edge clock
//   rstN              in   asynchronous assert, active-low reset
//   imemReq           out  fetch request, held until imemAck
//   imemAddr          out  fetch byte address (the current PC)
//   imemAck           in   memory accepts request; imemData valid this cycle
//   imemData          in   instruction word
//   instrValid        out  instrOut/opcode/funct are valid and held
//   instrOut          out  current instruction register
//   instructionOpcode out  instrOut[31:26]
//   instructionFunct  out  instrOut[5:0]
//   pcOut             out  address of the current instruction
//   pcPlus4           out  pcOut + 4 (wraps)
//   instrDone         in   datapath finished the current instruction
//   controlBranch     in   decoder: branch (beq)
//   controlJump       in   decoder: jump
//   aluZero           in   ALU zero flag, sampled with instrDone
//   fetchError        out  sticky watchdog error
//
// Downstream logic must gate the decoder outputs with instrValid. The reset
// value of instrOut is 0, which decodes as an R-type instruction.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h00000000,
  parameter int unsigned           MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  output logic                  imemReq,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic                  imemAck,
  input  logic [31:0]           imemData,
  output logic                  instrValid,
  output logic [31:0]           instrOut,
  output logic [5:0]            instructionOpcode,
  output logic [5:0]            instructionFunct,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic [ADDR_WIDTH-1:0] pcPlus4,
  input  logic                  instrDone,
  input  logic                  controlBranch,
  input  logic                  controlJump,
  input  logic                  aluZero,
  output logic                  fetchError
);

  // Reject parameter sets the address arithmetic below cannot represent.
  if (ADDR_WIDTH < 29) begin : gBadAddrWidth
    $error("instruction_fetch_unit: ADDR_WIDTH must be at least 29");
  end
  if (MAX_WAIT < 1) begin : gBadMaxWait
    $error("instruction_fetch_unit: MAX_WAIT must be at least 1");
  end

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } fetchState_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  fetchState_t           stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] pcReg, pcNext;
  logic [31:0]           instrReg, instrNext;

  logic [ADDR_WIDTH-1:0] jumpTarget;
  logic [ADDR_WIDTH-1:0] branchOffset;
  logic [ADDR_WIDTH-1:0] branchTarget;
  logic [ADDR_WIDTH-1:0] redirectPc;

`ifdef IFU_TIMEOUT_EN
  localparam int unsigned         WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  logic [WAIT_W-1:0]              waitCntReg;
`endif

  // -------------------------------------------------------------------------
  // Next-PC selection. Only the instrDone cycle uses it, so the controls
  // are effectively sampled there. A jump overrides a branch.
  // -------------------------------------------------------------------------
  assign pcPlus4      = pcReg + PC_STEP;
  assign jumpTarget   = {pcPlus4[ADDR_WIDTH-1:28], instrReg[25:0], 2'b00};
  assign branchOffset = {{(ADDR_WIDTH-18){instrReg[15]}}, instrReg[15:0], 2'b00};
  assign branchTarget = pcPlus4 + branchOffset;

  always_comb begin
    redirectPc = pcPlus4;
    if (controlJump) begin
      redirectPc = jumpTarget;
    end else if (controlBranch && aluZero) begin
      redirectPc = branchTarget;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext  = stateReg;
    pcNext     = pcReg;
    instrNext  = instrReg;
    imemReq    = 1'b0;
    instrValid = 1'b0;
    case (stateReg)
      RST: begin
        stateNext = FETCH;
      end
      FETCH: begin
        imemReq = 1'b1;
        // An ack on the watchdog's last cycle still completes the fetch.
        if (imemAck) begin
          instrNext = imemData;
          stateNext = HOLD;
        end
`ifdef IFU_TIMEOUT_EN
        else if (waitCntReg == WAIT_LAST) begin
          stateNext = ERROR;
        end
`endif
      end
      HOLD: begin
        instrValid = 1'b1;
        if (instrDone) begin
          pcNext    = redirectPc;
          stateNext = FETCH;
        end
      end
      default: begin
        // ERROR: parked until reset with request and valid low.
        stateNext = stateReg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg <= RST;
      pcReg    <= RESET_PC;
      instrReg <= 32'h0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      instrReg <= instrNext;
    end
  end

`ifdef IFU_TIMEOUT_EN
  // Counts FETCH cycles without an ack. It restarts whenever FETCH is
  // entered, so every fetch gets its own MAX_WAIT budget.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      waitCntReg <= '0;
    end else if (stateReg != FETCH) begin
      waitCntReg <= '0;
    end else if (!imemAck) begin
      waitCntReg <= waitCntReg + WAIT_W'(1);
    end
  end

  // ERROR is only left through reset, so the state alone keeps the error sticky.
  assign fetchError = (stateReg == ERROR);
`else
  assign fetchError = 1'b0;
`endif

  assign imemAddr          = pcReg;
  assign pcOut             = pcReg;
  assign instrOut          = instrReg;
  assign instructionOpcode = instrReg[31:26];
  assign instructionFunct  = instrReg[5:0];

endmodule
